// File: rtl/pop_counter.sv
// rtl/pop_counter.sv - per dest/VC counters of words popped from the D0/D1 output FIFOs
// Counters are read back through a req/idx/valid handshake that only opens while idle.
module pop_counter #(
    parameter int data_width  = 6,
    parameter int count_width = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   D0_pop,
    input  logic                   D1_pop,
    input  logic                   D0_empty,
    input  logic                   D1_empty,
    input  logic [data_width-1:0]  data_out_D0,
    input  logic [data_width-1:0]  data_out_D1,
    input  logic                   idle,
    input  logic                   clr,
    input  logic                   req,
    input  logic [1:0]             idx,
    output logic [count_width-1:0] data,
    output logic                   valid,
    output logic                   sat
);

    typedef enum logic {COUNT, READ} state_t;

    localparam logic [count_width-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [count_width-1:0] cnt [4];
    logic [3:0]             inc;
    logic [3:0]             at_max;
    logic                   pop0;
    logic                   pop1;

    assign pop0 = D0_pop & ~D0_empty;
    assign pop1 = D1_pop & ~D1_empty;

    // D0 and D1 always map to different counters, so both pops can land in one cycle.
    always_comb begin
        inc = '0;
        if (pop0) inc[{1'b0, data_out_D0[data_width-1]}] = 1'b1;
        if (pop1) inc[{1'b1, data_out_D1[data_width-1]}] = 1'b1;
    end

    always_comb begin
        at_max = '0;
        for (int i = 0; i < 4; i++) at_max[i] = (cnt[i] == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            sat <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (inc[i] && !at_max[i]) cnt[i] <= cnt[i] + 1'b1;
            end
            if (|(inc & at_max)) sat <= 1'b1;
        end
    end

    // Readout samples the registered counters, so a same-edge pop shows up one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COUNT;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                COUNT: begin
                    valid <= 1'b0;
                    if (req && idle) begin
                        state <= READ;
                        data  <= cnt[idx];
                        valid <= 1'b1;
                    end
                end
                READ: begin
                    if (req) begin
                        data  <= cnt[idx];
                        valid <= 1'b1;
                    end else begin
                        valid <= 1'b0;
                        state <= COUNT;
                    end
                end
                default: begin
                    state <= COUNT;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pop_counter.sv
// tb/tb_pop_counter.sv - scoreboard bench for pop_counter
module tb_pop_counter;

    localparam int DW = 6;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          D0_pop = 1'b0;
    logic          D1_pop = 1'b0;
    logic          D0_empty = 1'b0;
    logic          D1_empty = 1'b0;
    logic [DW-1:0] data_out_D0 = '0;
    logic [DW-1:0] data_out_D1 = '0;
    logic          idle = 1'b1;
    logic          clr = 1'b0;
    logic          req = 1'b0;
    logic [1:0]    idx = 2'd0;
    logic [CW-1:0] data;
    logic          valid;
    logic          sat;

    int checks = 0;
    int errors = 0;
    int model [4] = '{0, 0, 0, 0};
    int sat_m = 0;
    int sb [$];

    pop_counter #(.data_width(DW), .count_width(CW)) dut (
        .clk(clk), .reset(reset),
        .D0_pop(D0_pop), .D1_pop(D1_pop),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
        .idle(idle), .clr(clr), .req(req), .idx(idx),
        .data(data), .valid(valid), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_pop(input int dest, input logic [DW-1:0] w);
        int i;
        i = dest * 2 + int'(w[DW-1]);
        if (model[i] == 31) sat_m = 1;
        else model[i]++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model[i] = 0;
        sat_m = 0;
    endtask

    // Advance to the next falling edge and score any readout word the DUT presents.
    task automatic step();
        @(negedge clk);
        if (valid === 1'b1) begin
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else check("rd_data", data, sb.pop_front());
        end
    endtask

    task automatic drive_pops(input logic p0, input logic e0, input logic [DW-1:0] w0,
                              input logic p1, input logic e1, input logic [DW-1:0] w1);
        D0_pop = p0; D0_empty = e0; data_out_D0 = w0;
        D1_pop = p1; D1_empty = e1; data_out_D1 = w1;
        if (p0 && !e0) model_pop(0, w0);
        if (p1 && !e1) model_pop(1, w1);
        step();
        D0_pop = 1'b0; D1_pop = 1'b0; D0_empty = 1'b0; D1_empty = 1'b0;
    endtask

    task automatic read_one(input int i);
        idle = 1'b1;
        check("pre_rd_valid", valid, 0);
        req = 1'b1;
        idx = 2'(i);
        sb.push_back(model[i]);
        step();
        check("rd_valid", valid, 1);
        req = 1'b0;
        step();
        check("rd_valid_drop", valid, 0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 4; i++) read_one(i);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_sat", sat, 0);
        reset = 1'b1;
        step();
        check("post_rst_valid", valid, 0);
        read_one(0);

        // Four VC0 and four VC1 words delivered through D0
        idle = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive_pops(1'b1, 1'b0, DW'(k), 1'b0, 1'b0, '0);
            drive_pops(1'b1, 1'b0, DW'(32 + k), 1'b0, 1'b0, '0);
        end
        idle = 1'b1;
        step();
        read_all();
        check("d0vc0_total", model[0], 4);

        // Pops while empty must be ignored
        repeat (5) drive_pops(1'b1, 1'b1, 6'b000001, 1'b0, 1'b0, '0);
        read_all();

        clr = 1'b1;
        model_clear();
        step();
        clr = 1'b0;
        check("clr_sat", sat, 0);
        repeat (3) drive_pops(1'b1, 1'b0, 6'b000001, 1'b1, 1'b0, 6'b100010);
        read_all();

        // Saturation on D0/VC1
        repeat (33) drive_pops(1'b1, 1'b0, 6'b100011, 1'b0, 1'b0, '0);
        check("sat_set", sat, sat_m);
        check("sat_expected", sat_m, 1);
        read_one(1);
        clr = 1'b1;
        model_clear();
        step();
        clr = 1'b0;
        check("sat_clr", sat, 0);
        read_all();

        // Request held off by idle, then a pop during READ
        idle = 1'b0;
        req = 1'b1;
        idx = 2'd2;
        repeat (3) begin
            step();
            check("wait_valid", valid, 0);
        end
        idle = 1'b1;
        sb.push_back(model[2]);
        step();
        check("read_entry_valid", valid, 1);
        sb.push_back(model[2]);
        drive_pops(1'b0, 1'b0, '0, 1'b1, 1'b0, 6'b000101);
        sb.push_back(model[2]);
        step();
        idle = 1'b0;
        sb.push_back(model[2]);
        step();
        check("read_idle_drop_valid", valid, 1);
        clr = 1'b1;
        sb.push_back(model[2]);
        step();
        clr = 1'b0;
        model_clear();
        sb.push_back(model[2]);
        step();
        check("clr_in_read_valid", valid, 1);
        req = 1'b0;
        step();
        check("read_exit_valid", valid, 0);
        check("sb_drained", sb.size(), 0);

        // Reset in the middle of a READ
        idle = 1'b1;
        drive_pops(1'b0, 1'b0, '0, 1'b1, 1'b0, 6'b100001);
        req = 1'b1;
        idx = 2'd3;
        sb.push_back(model[3]);
        step();
        check("pre_reset_valid", valid, 1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_data", data, 0);
        sb.delete();
        model_clear();
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        read_one(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
